alu_reservation_station: RTL and testbench

- Holds decoded ALU/branch/jump instructions until both source operands are available, then issues one ready entry per cycle to the combinational ALU.
- Sits between the issue/decode stage, which dispatches into it, and the ALU, which it drives.
- Snoops the ALU and LSB common-data-bus broadcasts to wake up waiting operands.
- Cleared by the ROB flush.

---
 rtl/alu_reservation_station.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU/branch/jump instructions
// until both operands are ready, snoops the ALU and LSB CDBs for wakeups and
// issues the lowest-index ready entry each cycle.
// Optional macro RS_CDB_BYPASS_EN: an entry whose pending operands match a
// broadcast in the current cycle may issue at this edge with the bypassed value.
module alu_reservation_station #(
  parameter int unsigned RS_SIZE     = 16,
  parameter int unsigned ROB_TAG_W   = 4,
  parameter int unsigned INST_TYPE_W = 6
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   rob_flush_in,
  input  logic                   dispatch_en_in,
  input  logic [INST_TYPE_W-1:0] dispatch_inst_type_in,
  input  logic [31:0]            dispatch_pc_in,
  input  logic [31:0]            dispatch_A_in,
  input  logic [ROB_TAG_W-1:0]   dispatch_dest_in,
  input  logic                   dispatch_qj_busy_in,
  input  logic [ROB_TAG_W-1:0]   dispatch_qj_in,
  input  logic [31:0]            dispatch_vj_in,
  input  logic                   dispatch_qk_busy_in,
  input  logic [ROB_TAG_W-1:0]   dispatch_qk_in,
  input  logic [31:0]            dispatch_vk_in,
  input  logic                   cdb_alu_en_in,
  input  logic [ROB_TAG_W-1:0]   cdb_alu_dest_in,
  input  logic [31:0]            cdb_alu_value_in,
  input  logic                   cdb_lsb_en_in,
  input  logic [ROB_TAG_W-1:0]   cdb_lsb_dest_in,
  input  logic [31:0]            cdb_lsb_value_in,
  output logic                   rs_full_out,
  output logic                   rs_en_out,
  output logic [31:0]            rs_vj_out,
  output logic [31:0]            rs_vk_out,
  output logic [31:0]            rs_A_out,
  output logic [ROB_TAG_W-1:0]   rs_dest_out,
  output logic [31:0]            rs_pc_out,
  output logic [INST_TYPE_W-1:0] rs_inst_type_out
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(RS_SIZE) + 1;

  // Control state (reset)
  logic [RS_SIZE-1:0]     busy_q, busy_d;
  logic [RS_SIZE-1:0]     qjb_q, qjb_d;
  logic [RS_SIZE-1:0]     qkb_q, qkb_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   full_q, full_d;
  logic                   en_q, en_d;
  logic [31:0]            o_vj_q, o_vj_d, o_vk_q, o_vk_d, o_a_q, o_a_d, o_pc_q, o_pc_d;
  logic [ROB_TAG_W-1:0]   o_dest_q, o_dest_d;
  logic [INST_TYPE_W-1:0] o_type_q, o_type_d;

  // Entry payload (no reset; qualified by busy)
  logic [INST_TYPE_W-1:0] type_q [RS_SIZE];
  logic [INST_TYPE_W-1:0] type_d [RS_SIZE];
  logic [31:0]            pc_q [RS_SIZE];
  logic [31:0]            pc_d [RS_SIZE];
  logic [31:0]            a_q [RS_SIZE];
  logic [31:0]            a_d [RS_SIZE];
  logic [ROB_TAG_W-1:0]   dest_q [RS_SIZE];
  logic [ROB_TAG_W-1:0]   dest_d [RS_SIZE];
  logic [ROB_TAG_W-1:0]   qj_q [RS_SIZE];
  logic [ROB_TAG_W-1:0]   qj_d [RS_SIZE];
  logic [ROB_TAG_W-1:0]   qk_q [RS_SIZE];
  logic [ROB_TAG_W-1:0]   qk_d [RS_SIZE];
  logic [31:0]            vj_q [RS_SIZE];
  logic [31:0]            vj_d [RS_SIZE];
  logic [31:0]            vk_q [RS_SIZE];
  logic [31:0]            vk_d [RS_SIZE];

  // Select / free-slot results
  logic [31:0]            vj_eff [RS_SIZE];
  logic [31:0]            vk_eff [RS_SIZE];
  logic [RS_SIZE-1:0]     elig;
  logic                   sel_found, free_found, do_disp;
  logic [IDX_W-1:0]       sel_idx, free_idx;

  // Eligibility (optionally with CDB bypass) and lowest-index encoders
  always_comb begin
    elig       = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      logic rj, rk;
      rj        = !qjb_q[i];
      rk        = !qkb_q[i];
      vj_eff[i] = vj_q[i];
      vk_eff[i] = vk_q[i];
`ifdef RS_CDB_BYPASS_EN
      if (qjb_q[i]) begin
        if (cdb_alu_en_in && qj_q[i] == cdb_alu_dest_in) begin
          rj = 1'b1; vj_eff[i] = cdb_alu_value_in;
        end else if (cdb_lsb_en_in && qj_q[i] == cdb_lsb_dest_in) begin
          rj = 1'b1; vj_eff[i] = cdb_lsb_value_in;
        end
      end
      if (qkb_q[i]) begin
        if (cdb_alu_en_in && qk_q[i] == cdb_alu_dest_in) begin
          rk = 1'b1; vk_eff[i] = cdb_alu_value_in;
        end else if (cdb_lsb_en_in && qk_q[i] == cdb_lsb_dest_in) begin
          rk = 1'b1; vk_eff[i] = cdb_lsb_value_in;
        end
      end
`endif
      elig[i] = busy_q[i] && rj && rk;
      if (elig[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Next state: flush, CDB wakeup, issue, dispatch, count/full update
  always_comb begin
    busy_d = busy_q;  qjb_d = qjb_q;  qkb_d = qkb_q;
    type_d = type_q;  pc_d = pc_q;  a_d = a_q;  dest_d = dest_q;
    qj_d = qj_q;  qk_d = qk_q;  vj_d = vj_q;  vk_d = vk_q;
    cnt_d = cnt_q;  full_d = full_q;  en_d = en_q;
    o_vj_d = o_vj_q;  o_vk_d = o_vk_q;  o_a_d = o_a_q;  o_pc_d = o_pc_q;
    o_dest_d = o_dest_q;  o_type_d = o_type_q;
    do_disp = 1'b0;
    if (rdy_in) begin
      if (rob_flush_in) begin
        busy_d = '0;
        cnt_d  = '0;
        full_d = 1'b0;
        en_d   = 1'b0;
      end else begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && qjb_q[i]) begin
            if (cdb_alu_en_in && qj_q[i] == cdb_alu_dest_in) begin
              qjb_d[i] = 1'b0; vj_d[i] = cdb_alu_value_in;
            end else if (cdb_lsb_en_in && qj_q[i] == cdb_lsb_dest_in) begin
              qjb_d[i] = 1'b0; vj_d[i] = cdb_lsb_value_in;
            end
          end
          if (busy_q[i] && qkb_q[i]) begin
            if (cdb_alu_en_in && qk_q[i] == cdb_alu_dest_in) begin
              qkb_d[i] = 1'b0; vk_d[i] = cdb_alu_value_in;
            end else if (cdb_lsb_en_in && qk_q[i] == cdb_lsb_dest_in) begin
              qkb_d[i] = 1'b0; vk_d[i] = cdb_lsb_value_in;
            end
          end
        end
        en_d = sel_found;
        if (sel_found) begin
          busy_d[sel_idx] = 1'b0;
          o_vj_d   = vj_eff[sel_idx];
          o_vk_d   = vk_eff[sel_idx];
          o_a_d    = a_q[sel_idx];
          o_pc_d   = pc_q[sel_idx];
          o_dest_d = dest_q[sel_idx];
          o_type_d = type_q[sel_idx];
        end
        // Full is judged on the registered flag, so an issue this cycle does
        // not open a slot for a same-cycle dispatch.
        do_disp = dispatch_en_in && !full_q && free_found;
        if (do_disp) begin
          busy_d[free_idx] = 1'b1;
          type_d[free_idx] = dispatch_inst_type_in;
          pc_d[free_idx]   = dispatch_pc_in;
          a_d[free_idx]    = dispatch_A_in;
          dest_d[free_idx] = dispatch_dest_in;
          qj_d[free_idx]   = dispatch_qj_in;
          qk_d[free_idx]   = dispatch_qk_in;
          qjb_d[free_idx]  = dispatch_qj_busy_in;
          vj_d[free_idx]   = dispatch_vj_in;
          qkb_d[free_idx]  = dispatch_qk_busy_in;
          vk_d[free_idx]   = dispatch_vk_in;
          if (dispatch_qj_busy_in) begin
            if (cdb_alu_en_in && dispatch_qj_in == cdb_alu_dest_in) begin
              qjb_d[free_idx] = 1'b0; vj_d[free_idx] = cdb_alu_value_in;
            end else if (cdb_lsb_en_in && dispatch_qj_in == cdb_lsb_dest_in) begin
              qjb_d[free_idx] = 1'b0; vj_d[free_idx] = cdb_lsb_value_in;
            end
          end
          if (dispatch_qk_busy_in) begin
            if (cdb_alu_en_in && dispatch_qk_in == cdb_alu_dest_in) begin
              qkb_d[free_idx] = 1'b0; vk_d[free_idx] = cdb_alu_value_in;
            end else if (cdb_lsb_en_in && dispatch_qk_in == cdb_lsb_dest_in) begin
              qkb_d[free_idx] = 1'b0; vk_d[free_idx] = cdb_lsb_value_in;
            end
          end
        end
        cnt_d  = cnt_q + CNT_W'(do_disp) - CNT_W'(sel_found);
        full_d = (cnt_d == CNT_W'(RS_SIZE));
      end
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q   <= '0;
      qjb_q    <= '0;
      qkb_q    <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      en_q     <= 1'b0;
      o_vj_q   <= '0;
      o_vk_q   <= '0;
      o_a_q    <= '0;
      o_pc_q   <= '0;
      o_dest_q <= '0;
      o_type_q <= '0;
    end else begin
      busy_q   <= busy_d;
      qjb_q    <= qjb_d;
      qkb_q    <= qkb_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      en_q     <= en_d;
      o_vj_q   <= o_vj_d;
      o_vk_q   <= o_vk_d;
      o_a_q    <= o_a_d;
      o_pc_q   <= o_pc_d;
      o_dest_q <= o_dest_d;
      o_type_q <= o_type_d;
    end
  end

  // Entry payload registers; contents only matter while busy
  always_ff @(posedge clk_in) begin
    type_q <= type_d;
    pc_q   <= pc_d;
    a_q    <= a_d;
    dest_q <= dest_d;
    qj_q   <= qj_d;
    qk_q   <= qk_d;
    vj_q   <= vj_d;
    vk_q   <= vk_d;
  end

  assign rs_full_out      = full_q;
  assign rs_en_out        = en_q;
  assign rs_vj_out        = o_vj_q;
  assign rs_vk_out        = o_vk_q;
  assign rs_A_out         = o_a_q;
  assign rs_dest_out      = o_dest_q;
  assign rs_pc_out        = o_pc_q;
  assign rs_inst_type_out = o_type_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: table of ready-operand
// instructions plus sequences for wakeup, dispatch-time wakeup, full, rdy
// stall and flush.
module tb_alu_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_flush_in, dispatch_en_in;
  logic [5:0]  dispatch_inst_type_in;
  logic [31:0] dispatch_pc_in, dispatch_A_in, dispatch_vj_in, dispatch_vk_in;
  logic [3:0]  dispatch_dest_in, dispatch_qj_in, dispatch_qk_in;
  logic        dispatch_qj_busy_in, dispatch_qk_busy_in;
  logic        cdb_alu_en_in, cdb_lsb_en_in;
  logic [3:0]  cdb_alu_dest_in, cdb_lsb_dest_in;
  logic [31:0] cdb_alu_value_in, cdb_lsb_value_in;
  logic        rs_full_out, rs_en_out;
  logic [31:0] rs_vj_out, rs_vk_out, rs_A_out, rs_pc_out;
  logic [3:0]  rs_dest_out;
  logic [5:0]  rs_inst_type_out;

  int checks = 0;
  int errors = 0;

  alu_reservation_station #(.RS_SIZE(16), .ROB_TAG_W(4), .INST_TYPE_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_flush_in(rob_flush_in),
    .dispatch_en_in(dispatch_en_in), .dispatch_inst_type_in(dispatch_inst_type_in),
    .dispatch_pc_in(dispatch_pc_in), .dispatch_A_in(dispatch_A_in),
    .dispatch_dest_in(dispatch_dest_in), .dispatch_qj_busy_in(dispatch_qj_busy_in),
    .dispatch_qj_in(dispatch_qj_in), .dispatch_vj_in(dispatch_vj_in),
    .dispatch_qk_busy_in(dispatch_qk_busy_in), .dispatch_qk_in(dispatch_qk_in),
    .dispatch_vk_in(dispatch_vk_in),
    .cdb_alu_en_in(cdb_alu_en_in), .cdb_alu_dest_in(cdb_alu_dest_in),
    .cdb_alu_value_in(cdb_alu_value_in),
    .cdb_lsb_en_in(cdb_lsb_en_in), .cdb_lsb_dest_in(cdb_lsb_dest_in),
    .cdb_lsb_value_in(cdb_lsb_value_in),
    .rs_full_out(rs_full_out), .rs_en_out(rs_en_out), .rs_vj_out(rs_vj_out),
    .rs_vk_out(rs_vk_out), .rs_A_out(rs_A_out), .rs_dest_out(rs_dest_out),
    .rs_pc_out(rs_pc_out), .rs_inst_type_out(rs_inst_type_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  itype;
    logic [31:0] pc, a, vj, vk;
    logic [3:0]  dest;
    logic [31:0] exp_vj, exp_vk, exp_a, exp_pc;
    logic [3:0]  exp_dest;
    logic [5:0]  exp_type;
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dispatch_en_in = 0; rob_flush_in = 0;
    dispatch_inst_type_in = '0; dispatch_pc_in = '0; dispatch_A_in = '0;
    dispatch_dest_in = '0; dispatch_qj_busy_in = 0; dispatch_qj_in = '0;
    dispatch_vj_in = '0; dispatch_qk_busy_in = 0; dispatch_qk_in = '0;
    dispatch_vk_in = '0;
    cdb_alu_en_in = 0; cdb_alu_dest_in = '0; cdb_alu_value_in = '0;
    cdb_lsb_en_in = 0; cdb_lsb_dest_in = '0; cdb_lsb_value_in = '0;
  endtask

  task automatic drive_disp(input logic [5:0] t, input logic [31:0] pc, input logic [31:0] a,
                            input logic [3:0] dest, input logic qjb, input logic [3:0] qj,
                            input logic [31:0] vj, input logic qkb, input logic [3:0] qk,
                            input logic [31:0] vk);
    dispatch_en_in = 1; dispatch_inst_type_in = t; dispatch_pc_in = pc; dispatch_A_in = a;
    dispatch_dest_in = dest; dispatch_qj_busy_in = qjb; dispatch_qj_in = qj;
    dispatch_vj_in = vj; dispatch_qk_busy_in = qkb; dispatch_qk_in = qk; dispatch_vk_in = vk;
  endtask

  initial begin
    vecs[0] = '{6'd1, 32'h100, 32'h0, 32'd5, 32'd7, 4'd3,
                32'd5, 32'd7, 32'h0, 32'h100, 4'd3, 6'd1};
    vecs[1] = '{6'd2, 32'h104, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 32'h1234_5678, 4'd15,
                32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFF0, 32'h104, 4'd15, 6'd2};
    vecs[2] = '{6'd63, 32'h8000_0000, 32'h7FF, 32'h0, 32'hFFFF_FFFF, 4'd0,
                32'h0, 32'hFFFF_FFFF, 32'h7FF, 32'h8000_0000, 4'd0, 6'd63};
    vecs[3] = '{6'd10, 32'h2C, 32'h4, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'd8,
                32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h4, 32'h2C, 4'd8, 6'd10};

    idle_inputs();
    rdy_in = 1;
    rst_in = 0;
    // Test 1: reset
    step(); step();
    rst_in = 1;
    step();
    chk("rst_en", 32'(rs_en_out), 0);
    chk("rst_full", 32'(rs_full_out), 0);
    chk("rst_vj", rs_vj_out, 0);
    chk("rst_vk", rs_vk_out, 0);
    chk("rst_A", rs_A_out, 0);
    chk("rst_pc", rs_pc_out, 0);
    chk("rst_dest", 32'(rs_dest_out), 0);
    chk("rst_type", 32'(rs_inst_type_out), 0);

    // Test 2: ready-operand instructions from the table
    for (int i = 0; i < 4; i++) begin
      drive_disp(vecs[i].itype, vecs[i].pc, vecs[i].a, vecs[i].dest,
                 0, 4'd0, vecs[i].vj, 0, 4'd0, vecs[i].vk);
      step();
      idle_inputs();
      chk("vec_en_lat0", 32'(rs_en_out), 0);
      step();
      chk("vec_en", 32'(rs_en_out), 1);
      chk("vec_vj", rs_vj_out, vecs[i].exp_vj);
      chk("vec_vk", rs_vk_out, vecs[i].exp_vk);
      chk("vec_A", rs_A_out, vecs[i].exp_a);
      chk("vec_pc", rs_pc_out, vecs[i].exp_pc);
      chk("vec_dest", 32'(rs_dest_out), 32'(vecs[i].exp_dest));
      chk("vec_type", 32'(rs_inst_type_out), 32'(vecs[i].exp_type));
      step();
      chk("vec_en_after", 32'(rs_en_out), 0);
      chk("vec_vj_hold", rs_vj_out, vecs[i].exp_vj);
    end

    // rdy_in low freezes issue and ignores dispatch
    drive_disp(6'd2, 32'h40, 32'h0, 4'd12, 0, 4'd0, 32'h11, 0, 4'd0, 32'h22);
    step();
    idle_inputs();
    rdy_in = 0;
    drive_disp(6'd3, 32'h44, 32'h0, 4'd13, 0, 4'd0, 32'h33, 0, 4'd0, 32'h44);
    step();
    chk("rdy0_en", 32'(rs_en_out), 0);
    idle_inputs();
    rdy_in = 1;
    step();
    chk("rdy1_en", 32'(rs_en_out), 1);
    chk("rdy1_vj", rs_vj_out, 32'h11);
    chk("rdy1_dest", 32'(rs_dest_out), 12);
    step();
    chk("rdy_ignored_disp", 32'(rs_en_out), 0);

    // Test 3: operand woken by ALU CDB
    drive_disp(6'd4, 32'h200, 32'd10, 4'd5, 1, 4'd6, 32'h0, 0, 4'd0, 32'h0);
    step();
    idle_inputs();
    chk("wk_en0", 32'(rs_en_out), 0);
    step();
    chk("wk_en1", 32'(rs_en_out), 0);
    cdb_alu_en_in = 1; cdb_alu_dest_in = 4'd6; cdb_alu_value_in = 32'h20;
    step();
    idle_inputs();
`ifdef RS_CDB_BYPASS_EN
    chk("wk_en_bypass", 32'(rs_en_out), 1);
`else
    chk("wk_en_bcast", 32'(rs_en_out), 0);
    step();
    chk("wk_en", 32'(rs_en_out), 1);
`endif
    chk("wk_vj", rs_vj_out, 32'h20);
    chk("wk_A", rs_A_out, 32'd10);
    chk("wk_dest", 32'(rs_dest_out), 5);
    step();
    chk("wk_en_after", 32'(rs_en_out), 0);

    // Test 4: dispatch-time wakeup from LSB CDB
    drive_disp(6'd5, 32'h300, 32'h0, 4'd7, 0, 4'd0, 32'd1, 1, 4'd2, 32'h0);
    cdb_lsb_en_in = 1; cdb_lsb_dest_in = 4'd2; cdb_lsb_value_in = 32'hABCD;
    step();
    idle_inputs();
    chk("dw_en0", 32'(rs_en_out), 0);
    step();
    chk("dw_en", 32'(rs_en_out), 1);
    chk("dw_vk", rs_vk_out, 32'hABCD);
    chk("dw_vj", rs_vj_out, 32'd1);
    chk("dw_dest", 32'(rs_dest_out), 7);
    step();

    // Test 5: fill all 16 entries with pending operands
    for (int i = 0; i < 16; i++) begin
      drive_disp(6'd1, 32'(i * 4), 32'h0, 4'(i), 1, 4'(i), 32'h0, 0, 4'd0, 32'(i));
      step();
      chk("fill_full", 32'(rs_full_out), (i == 15) ? 1 : 0);
    end
    chk("fill_en", 32'(rs_en_out), 0);
    drive_disp(6'd9, 32'h900, 32'h0, 4'd15, 0, 4'd0, 32'h77, 0, 4'd0, 32'h88);
    step();
    idle_inputs();
    chk("ovf_full", 32'(rs_full_out), 1);
    chk("ovf_en0", 32'(rs_en_out), 0);
    step();
    chk("ovf_en1", 32'(rs_en_out), 0);
    cdb_alu_en_in = 1; cdb_alu_dest_in = 4'd9; cdb_alu_value_in = 32'h99;
    step();
    idle_inputs();
`ifndef RS_CDB_BYPASS_EN
    chk("full_wk_en", 32'(rs_en_out), 0);
    chk("full_wk_full", 32'(rs_full_out), 1);
    step();
`endif
    chk("full_iss_en", 32'(rs_en_out), 1);
    chk("full_iss_vj", rs_vj_out, 32'h99);
    chk("full_iss_vk", rs_vk_out, 32'd9);
    chk("full_iss_dest", 32'(rs_dest_out), 9);
    chk("full_iss_full", 32'(rs_full_out), 0);
    step();
    chk("full_after_en", 32'(rs_en_out), 0);

    // Test 6: flush clears waiting entries and drops same-cycle dispatch
    rob_flush_in = 1;
    step();
    rob_flush_in = 0;
    chk("fl0_full", 32'(rs_full_out), 0);
    for (int i = 1; i <= 3; i++) begin
      drive_disp(6'd1, 32'h500, 32'h0, 4'(i), 1, 4'(i), 32'h0, 0, 4'd0, 32'h0);
      step();
    end
    drive_disp(6'd1, 32'h600, 32'h0, 4'd10, 0, 4'd0, 32'h1, 0, 4'd0, 32'h2);
    rob_flush_in = 1;
    step();
    idle_inputs();
    chk("fl_en", 32'(rs_en_out), 0);
    chk("fl_full", 32'(rs_full_out), 0);
    step();
    chk("fl_drop_en", 32'(rs_en_out), 0);
    for (int i = 1; i <= 3; i++) begin
      cdb_alu_en_in = 1; cdb_alu_dest_in = 4'(i); cdb_alu_value_in = 32'(i);
      step();
      chk("fl_old_tag_en", 32'(rs_en_out), 0);
    end
    idle_inputs();
    step();
    chk("fl_old_tag_en_last", 32'(rs_en_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
